// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 responder (MSB first) with every pin oversampled in the CLK_100MHz domain.
// The host side has a one-entry TX holding register and a one-entry RX register, each with a valid/ready handshake.
module spi_responder #(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] FILL        = WIDTH'(8'hFF)
) (
   input  logic             CLK_100MHz,
   input  logic             reset_n,
   input  logic             SPI_SCK,
   input  logic             SPI_CSX,
   input  logic             SPI_SDI,
   output logic             SPI_SDO,
   output logic             SDO_OE,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ack,
   output logic             rx_overrun,
   output logic             tx_underrun
);

   localparam int               CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT
   } state_t;

   state_t state;
   state_t next_state;

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] csx_sync;
   logic [SYNC_STAGES-1:0] sdi_sync;
   logic                   ssck_q;
   logic                   ssck;
   logic                   scs;
   logic                   ssdi;
   logic                   rise;
   logic                   fall;

   logic [WIDTH-1:0]       shreg;
   logic [WIDTH-1:0]       rxsh;
   logic [CNT_W-1:0]       bit_cnt;
   logic                   word_done;
   logic [WIDTH-1:0]       hold_data;
   logic                   hold_full;
   logic                   sdo_oe;

   logic                   accept;
   logic                   do_load;
   logic                   do_shift;
   logic                   do_rise;
   logic                   word_complete;
   logic                   load_fill;
   logic [WIDTH-1:0]       load_word;
   logic [WIDTH-1:0]       rx_word;

   // CSX presets high so a reset never looks like a selection.
   always_ff @(posedge CLK_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync <= '0;
         csx_sync <= '1;
         sdi_sync <= '0;
         ssck_q   <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
         csx_sync <= {csx_sync[SYNC_STAGES-2:0], SPI_CSX};
         sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], SPI_SDI};
         ssck_q   <= ssck;
      end
   end

   assign ssck = sck_sync[SYNC_STAGES-1];
   assign scs  = csx_sync[SYNC_STAGES-1];
   assign ssdi = sdi_sync[SYNC_STAGES-1];
   assign rise = ssck & ~ssck_q;
   assign fall = ~ssck & ssck_q;

   always_ff @(posedge CLK_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Deselection wins over any SCK edge seen in the same cycle, so a final
   // SCK fall that coincides with CSX rising does not trigger a reload.
   always_comb begin
      next_state    = state;
      do_load       = 1'b0;
      do_shift      = 1'b0;
      do_rise       = 1'b0;
      word_complete = 1'b0;
      case (state)
         IDLE: begin
            if (!scs) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            if (scs) begin
               next_state = IDLE;
            end else begin
               next_state = SHIFT;
               do_load    = 1'b1;
            end
         end
         SHIFT: begin
            if (scs) begin
               next_state = IDLE;
            end else begin
               do_rise       = rise;
               word_complete = rise && (bit_cnt == LAST_BIT);
               do_load       = fall && word_done;
               do_shift      = fall && !word_done;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // A word offered in the same cycle as a load goes straight to the shifter.
   assign tx_ready  = ~hold_full;
   assign accept    = tx_valid & tx_ready;
   assign load_fill = do_load & ~hold_full & ~accept;
   assign load_word = hold_full ? hold_data : (accept ? tx_data : FILL);
   assign rx_word   = {rxsh[WIDTH-2:0], ssdi};

   always_ff @(posedge CLK_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         hold_data <= '0;
         hold_full <= 1'b0;
      end else if (do_load) begin
         hold_full <= 1'b0;
      end else if (accept) begin
         hold_data <= tx_data;
         hold_full <= 1'b1;
      end
   end

   always_ff @(posedge CLK_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         shreg     <= '0;
         rxsh      <= '0;
         bit_cnt   <= '0;
         word_done <= 1'b0;
         sdo_oe    <= 1'b0;
      end else begin
         sdo_oe <= (next_state == SHIFT);
         if (do_load) begin
            shreg     <= load_word;
            bit_cnt   <= '0;
            word_done <= 1'b0;
         end else if (do_shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
         end
         if (do_rise) begin
            rxsh    <= rx_word;
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
         if (word_complete) begin
            word_done <= 1'b1;
         end
      end
   end

   // An acknowledge landing on the completion cycle is absorbed by the new word.
   always_ff @(posedge CLK_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         rx_overrun  <= word_complete & rx_valid & ~rx_ack;
         tx_underrun <= load_fill;
         if (word_complete) begin
            rx_data  <= rx_word;
            rx_valid <= 1'b1;
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign SPI_SDO = shreg[WIDTH-1];
   assign SDO_OE  = sdo_oe;

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed mode-0 frames driven at SCK = CLK/8 against spi_responder,
// with hand-computed expected SDO words, received words and pulse counts.
module tb_spi_responder;

   logic       clk;
   logic       reset_n;
   logic       SPI_SCK;
   logic       SPI_CSX;
   logic       SPI_SDI;
   logic       SPI_SDO;
   logic       SDO_OE;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       rx_overrun;
   logic       tx_underrun;

   int checks;
   int errors;
   int underrun_cnt;
   int overrun_cnt;
   int u0;
   int o0;
   logic [7:0] sdo_a;
   logic [7:0] sdo_b;

   spi_responder #(
      .WIDTH      (8),
      .SYNC_STAGES(2),
      .FILL       (8'hFF)
   ) dut (
      .CLK_100MHz (clk),
      .reset_n    (reset_n),
      .SPI_SCK    (SPI_SCK),
      .SPI_CSX    (SPI_CSX),
      .SPI_SDI    (SPI_SDI),
      .SPI_SDO    (SPI_SDO),
      .SDO_OE     (SDO_OE),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ack     (rx_ack),
      .rx_overrun (rx_overrun),
      .tx_underrun(tx_underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters let each scenario check how many pulses it produced.
   always @(posedge clk) begin
      if (tx_underrun) underrun_cnt <= underrun_cnt + 1;
      if (rx_overrun)  overrun_cnt  <= overrun_cnt + 1;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 2 ms");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One word (or the first nbits of it), MSB first; SDO is captured just before each rise.
   task automatic applyStimulus(input logic [7:0] word, input int nbits, input bit ack_last,
                                output logic [7:0] sdo_word);
      sdo_word = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         SPI_SCK = 1'b0;
         SPI_SDI = word[7-i];
         repeat (4) @(negedge clk);
         sdo_word = {sdo_word[6:0], SPI_SDO};
         SPI_SCK = 1'b1;
         if (ack_last && (i == nbits - 1)) begin
            repeat (2) @(negedge clk);
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
            @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
      end
   endtask

   task automatic selectDevice();
      SPI_CSX = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("sdo_oe_on", 16'(SDO_OE), 16'h1);
   endtask

   // The final SCK fall and CSX rise land together, as the Hack master does.
   task automatic deselectDevice();
      SPI_SCK = 1'b0;
      SPI_CSX = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("sdo_oe_off", 16'(SDO_OE), 16'h0);
      repeat (5) @(negedge clk);
   endtask

   task automatic loadTx(input logic [7:0] word);
      int n;
      n = 0;
      tx_data  = word;
      tx_valid = 1'b1;
      while (!tx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("tx_ready_wait", 16'(tx_ready), 16'h1);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic waitRx();
      int n;
      n = 0;
      while (!rx_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rx_valid_wait", 16'(rx_valid), 16'h1);
   endtask

   task automatic ackRx();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      checkOutput("rx_valid_clear", 16'(rx_valid), 16'h0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      underrun_cnt = 0;
      overrun_cnt  = 0;
      reset_n      = 1'b0;
      SPI_SCK      = 1'b0;
      SPI_CSX      = 1'b1;
      SPI_SDI      = 1'b0;
      tx_data      = 8'h00;
      tx_valid     = 1'b0;
      rx_ack       = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] reset values");
      checkOutput("rst_sdo",      16'(SPI_SDO),     16'h0);
      checkOutput("rst_sdo_oe",   16'(SDO_OE),      16'h0);
      checkOutput("rst_tx_ready", 16'(tx_ready),    16'h1);
      checkOutput("rst_rx_data",  16'(rx_data),     16'h00);
      checkOutput("rst_rx_valid", 16'(rx_valid),    16'h0);
      checkOutput("rst_overrun",  16'(rx_overrun),  16'h0);
      checkOutput("rst_underrun", 16'(tx_underrun), 16'h0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] tx A5 / rx 3C");
      loadTx(8'hA5);
      checkOutput("tx_ready_held", 16'(tx_ready), 16'h0);
      u0 = underrun_cnt;
      selectDevice();
      checkOutput("tx_ready_after_load", 16'(tx_ready), 16'h1);
      applyStimulus(8'h3C, 8, 1'b0, sdo_a);
      deselectDevice();
      checkOutput("t1_sdo", 16'(sdo_a), 16'h00A5);
      waitRx();
      checkOutput("t1_rx_data", 16'(rx_data), 16'h003C);
      checkOutput("t1_underruns", 16'(underrun_cnt - u0), 16'h0);
      ackRx();

      $display("[TB] empty holding register sends FILL");
      u0 = underrun_cnt;
      selectDevice();
      applyStimulus(8'h00, 8, 1'b0, sdo_a);
      deselectDevice();
      checkOutput("t2_sdo", 16'(sdo_a), 16'h00FF);
      waitRx();
      checkOutput("t2_rx_data", 16'(rx_data), 16'h0000);
      checkOutput("t2_underruns", 16'(underrun_cnt - u0), 16'h1);
      ackRx();

      $display("[TB] back-to-back 11/22 with tx 55/66");
      loadTx(8'h55);
      u0 = underrun_cnt;
      o0 = overrun_cnt;
      selectDevice();
      loadTx(8'h66);
      applyStimulus(8'h11, 8, 1'b0, sdo_a);
      checkOutput("t3_rx_first", 16'(rx_data), 16'h0011);
      applyStimulus(8'h22, 8, 1'b0, sdo_b);
      deselectDevice();
      checkOutput("t3_sdo_first",  16'(sdo_a), 16'h0055);
      checkOutput("t3_sdo_second", 16'(sdo_b), 16'h0066);
      checkOutput("t3_rx_data",    16'(rx_data), 16'h0022);
      checkOutput("t3_rx_valid",   16'(rx_valid), 16'h1);
      checkOutput("t3_overruns",   16'(overrun_cnt - o0), 16'h1);
      checkOutput("t3_underruns",  16'(underrun_cnt - u0), 16'h0);
      ackRx();

      $display("[TB] abort after 5 bits, then 81");
      selectDevice();
      applyStimulus(8'hAA, 5, 1'b0, sdo_a);
      deselectDevice();
      repeat (10) @(negedge clk);
      checkOutput("t4_rx_valid_abort", 16'(rx_valid), 16'h0);
      checkOutput("t4_rx_data_kept",   16'(rx_data), 16'h0022);
      selectDevice();
      applyStimulus(8'h81, 8, 1'b0, sdo_a);
      deselectDevice();
      checkOutput("t4_sdo", 16'(sdo_a), 16'h00FF);
      waitRx();
      checkOutput("t4_rx_data", 16'(rx_data), 16'h0081);
      ackRx();

      $display("[TB] reset mid-frame, then F0");
      selectDevice();
      loadTx(8'h77);
      checkOutput("t5_tx_ready_held", 16'(tx_ready), 16'h0);
      applyStimulus(8'h5A, 3, 1'b0, sdo_a);
      reset_n = 1'b0;
      #1;
      checkOutput("t5_rst_sdo",      16'(SPI_SDO),  16'h0);
      checkOutput("t5_rst_sdo_oe",   16'(SDO_OE),   16'h0);
      checkOutput("t5_rst_tx_ready", 16'(tx_ready), 16'h1);
      checkOutput("t5_rst_rx_data",  16'(rx_data),  16'h0000);
      checkOutput("t5_rst_rx_valid", 16'(rx_valid), 16'h0);
      SPI_SCK = 1'b0;
      SPI_CSX = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      selectDevice();
      applyStimulus(8'hF0, 8, 1'b0, sdo_a);
      deselectDevice();
      checkOutput("t5_sdo", 16'(sdo_a), 16'h00FF);
      waitRx();
      checkOutput("t5_rx_data", 16'(rx_data), 16'h00F0);
      ackRx();

      $display("[TB] rx_ack coincident with completion of 99");
      o0 = overrun_cnt;
      selectDevice();
      applyStimulus(8'h12, 8, 1'b0, sdo_a);
      checkOutput("t6_rx_first", 16'(rx_data), 16'h0012);
      applyStimulus(8'h99, 8, 1'b1, sdo_b);
      deselectDevice();
      checkOutput("t6_rx_valid", 16'(rx_valid), 16'h1);
      checkOutput("t6_rx_data",  16'(rx_data),  16'h0099);
      checkOutput("t6_overruns", 16'(overrun_cnt - o0), 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
